// File: rtl/conv_pkg.sv
// conv_pkg: shared constants and helpers for the convolution datapath.
//   DefImgW/DefImgH/DefK/DefDataBits : default geometry of the first conv layer
//   win_idx(r, c, k)                 : flat element index r*k+c of a k x k window
//                                      (r=0 is the top/oldest row, c=0 the leftmost column)
package conv_pkg;

  localparam int unsigned DefImgW     = 28;
  localparam int unsigned DefImgH     = 28;
  localparam int unsigned DefK        = 5;
  localparam int unsigned DefDataBits = 8;

  function automatic int unsigned win_idx(input int unsigned r, input int unsigned c,
                                          input int unsigned k = DefK);
    return r * k + c;
  endfunction

endpackage

// File: rtl/conv_line_delay.sv
// conv_line_delay: one image row of pixel delay (DEPTH entries), advancing only when enabled.
// A pixel pushed on one enabled beat appears on o_data DEPTH enabled beats later.
// Contents are not reset: they are always refilled before the window logic uses them.
// Ports:
//   clk    in  clock, rising edge
//   i_en   in  shift enable (accepted pixel beat)
//   i_data in  pixel entering the line
//   o_data out pixel from DEPTH beats ago
module conv_line_delay
  import conv_pkg::*;
#(
  parameter int unsigned DEPTH     = DefImgW,
  parameter int unsigned DATA_BITS = DefDataBits
) (
  input  logic                 clk,
  input  logic                 i_en,
  input  logic [DATA_BITS-1:0] i_data,
  output logic [DATA_BITS-1:0] o_data
);

  logic [DATA_BITS-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_mem[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_mem[i] <= r_mem[i-1];
      end
    end
  end

  assign o_data = r_mem[DEPTH-1];

endmodule

// File: rtl/conv_window_buf.sv
// conv_window_buf: streaming K x K sliding-window generator (valid padding).
// Accepts one raster-order pixel per valid_in beat and emits a registered window one cycle
// after each beat that completes a valid convolution position.
// Build option: define CONV_BUF_STRIDE2_EN to emit only stride-2 positions (default stride 1).
// Ports:
//   clk        in  clock, rising edge
//   rst_n      in  synchronous active-low reset
//   valid_in   in  pixel beat qualifier; low cycles freeze all state
//   sof        in  start of frame (with valid_in): current pixel becomes (0,0)
//   data_in    in  pixel
//   win_data   out flattened window, element r*K+c at [(r*K+c)*DATA_BITS +: DATA_BITS]
//   valid_out  out one-cycle pulse per emitted window
//   frame_done out pulses with the last window of a frame
module conv_window_buf
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W     = DefImgW,
  parameter int unsigned IMG_H     = DefImgH,
  parameter int unsigned K         = DefK,
  parameter int unsigned DATA_BITS = DefDataBits
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_in,
  input  logic                       sof,
  input  logic [DATA_BITS-1:0]       data_in,
  output logic [K*K*DATA_BITS-1:0]   win_data,
  output logic                       valid_out,
  output logic                       frame_done
);

  localparam int unsigned ColW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RowW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned WinW = K * K * DATA_BITS;

`ifdef CONV_BUF_STRIDE2_EN
  // Last emitted position: largest even offset from K-1 that still fits in the image.
  localparam int unsigned LastRow = K - 1 + ((IMG_H - K) / 2) * 2;
  localparam int unsigned LastCol = K - 1 + ((IMG_W - K) / 2) * 2;
  // (pos - (K-1)) is even exactly when pos has the same parity as K-1.
  localparam logic        KPar    = 1'((K - 1) % 2);
`else
  localparam int unsigned LastRow = IMG_H - 1;
  localparam int unsigned LastCol = IMG_W - 1;
`endif

  logic [ColW-1:0]      r_col, w_col_cur, w_col_nxt;
  logic [RowW-1:0]      r_row, w_row_cur, w_row_nxt;
  logic [WinW-1:0]      r_win, w_win_nxt;
  logic                 r_valid_out, r_frame_done;
  logic                 w_emit, w_last, w_phase_ok;
  logic [DATA_BITS-1:0] w_line_in  [K-1];
  logic [DATA_BITS-1:0] w_tap      [K-1];
  logic [DATA_BITS-1:0] w_new_col  [K];

  // Position of the pixel on the current beat; sof overrides the running counters.
  always_comb begin
    w_col_cur = sof ? '0 : r_col;
    w_row_cur = sof ? '0 : r_row;
    w_col_nxt = w_col_cur + ColW'(1);
    w_row_nxt = w_row_cur;
    if (w_col_cur == ColW'(IMG_W - 1)) begin
      w_col_nxt = '0;
      w_row_nxt = (w_row_cur == RowW'(IMG_H - 1)) ? '0 : w_row_cur + RowW'(1);
    end
  end

  always_comb begin
`ifdef CONV_BUF_STRIDE2_EN
    w_phase_ok = (w_row_cur[0] == KPar) && (w_col_cur[0] == KPar);
`else
    w_phase_ok = 1'b1;
`endif
    w_emit = (32'(w_row_cur) >= K - 1) && (32'(w_col_cur) >= K - 1) && w_phase_ok;
    w_last = (w_row_cur == RowW'(LastRow)) && (w_col_cur == ColW'(LastCol));
  end

  // Chained row delays: tap i holds the pixel i+1 rows above data_in.
  for (genvar gi = 0; gi < K - 1; gi++) begin : g_line
    if (gi == 0) begin : g_head
      assign w_line_in[gi] = data_in;
    end else begin : g_chain
      assign w_line_in[gi] = w_tap[gi-1];
    end

    conv_line_delay #(
      .DEPTH     (IMG_W),
      .DATA_BITS (DATA_BITS)
    ) u_line (
      .clk    (clk),
      .i_en   (valid_in),
      .i_data (w_line_in[gi]),
      .o_data (w_tap[gi])
    );
  end

  // New right-hand column, top (oldest row) first.
  always_comb begin
    w_new_col[K-1] = data_in;
    for (int r = 0; r < K - 1; r++) begin
      w_new_col[r] = w_tap[K-2-r];
    end
  end

  // Shift the window one column left and insert the new column on the right.
  always_comb begin
    w_win_nxt = r_win;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        w_win_nxt[win_idx(r, c, K)*DATA_BITS +: DATA_BITS] =
          r_win[win_idx(r, c + 1, K)*DATA_BITS +: DATA_BITS];
      end
      w_win_nxt[win_idx(r, K - 1, K)*DATA_BITS +: DATA_BITS] = w_new_col[r];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col        <= '0;
      r_row        <= '0;
      r_win        <= '0;
      r_valid_out  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_valid_out  <= valid_in && w_emit;
      r_frame_done <= valid_in && w_emit && w_last;
      if (valid_in) begin
        r_col <= w_col_nxt;
        r_row <= w_row_nxt;
        r_win <= w_win_nxt;
      end
    end
  end

  assign win_data   = r_win;
  assign valid_out  = r_valid_out;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_conv_window_buf.sv
// Testbench for conv_window_buf with default geometry (28x28, K=5, 8-bit pixels).
// Ramp frames: pixel at (r,c) = (r*28+c) mod 256, i.e. raster index mod 256.
// Honours CONV_BUF_STRIDE2_EN to select the stride-2 expectations.
module tb_conv_window_buf;

  localparam int unsigned W    = 28;
  localparam int unsigned H    = 28;
  localparam int unsigned K    = 5;
  localparam int unsigned DB   = 8;
  localparam int unsigned WinW = K * K * DB;
  localparam int          NPIX = W * H;
`ifdef CONV_BUF_STRIDE2_EN
  localparam int          NWIN = 144;
`else
  localparam int          NWIN = 576;
`endif

  logic            clk      = 1'b0;
  logic            rst_n    = 1'b0;
  logic            valid_in = 1'b0;
  logic            sof      = 1'b0;
  logic [DB-1:0]   data_in  = '0;
  logic [WinW-1:0] win_data;
  logic            valid_out;
  logic            frame_done;

  int n_checks = 0;
  int n_pass   = 0;

  logic            obs_v   [NPIX];
  logic            obs_fd  [NPIX];
  logic            obs_bv  [NPIX];
  logic            obs_bfd [NPIX];
  logic [WinW-1:0] obs_w   [NPIX];
  logic            exp_v   [NPIX];
  logic            exp_fd  [NPIX];
  logic [WinW-1:0] exp_w   [NPIX];

  conv_window_buf #(
    .IMG_W     (W),
    .IMG_H     (H),
    .K         (K),
    .DATA_BITS (DB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .sof        (sof),
    .data_in    (data_in),
    .win_data   (win_data),
    .valid_out  (valid_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic f_emit(input int i);
    int row = i / W;
    int col = i % W;
    logic e = (row >= K - 1) && (col >= K - 1);
`ifdef CONV_BUF_STRIDE2_EN
    e = e && ((row - (K - 1)) % 2 == 0) && ((col - (K - 1)) % 2 == 0);
`endif
    return e;
  endfunction

  function automatic logic f_last(input int i);
`ifdef CONV_BUF_STRIDE2_EN
    return (i / W == 26) && (i % W == 26);
`else
    return i == NPIX - 1;
`endif
  endfunction

  function automatic logic [WinW-1:0] f_win(input int i);
    int row = i / W;
    int col = i % W;
    logic [WinW-1:0] v = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        v[(r*K+c)*DB +: DB] = DB'(((row - K + 1 + r) * W + (col - K + 1 + c)) % 256);
      end
    end
    return v;
  endfunction

  task automatic build_expected();
    for (int i = 0; i < NPIX; i++) begin
      exp_v[i]  = f_emit(i);
      exp_fd[i] = f_emit(i) && f_last(i);
      exp_w[i]  = f_emit(i) ? f_win(i) : '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives nbeats ramp pixels (optionally with a bubble after each) and records outputs.
  // Leaves valid_in high so consecutive calls form a gap-free stream.
  task automatic drive_frame(input bit first_sof, input bit bubbles, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      valid_in = 1'b1;
      sof      = first_sof && (i == 0);
      data_in  = DB'(i % 256);
      tick();
      obs_v[i]  = valid_out;
      obs_fd[i] = frame_done;
      obs_w[i]  = win_data;
      if (bubbles) begin
        valid_in = 1'b0;
        sof      = 1'b1;   // must be ignored without valid_in
        data_in  = 8'hA5;
        tick();
        obs_bv[i]  = valid_out;
        obs_bfd[i] = frame_done;
      end
    end
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    sof      = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    valid_in = 1'b1;
    sof      = 1'b1;
    data_in  = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (valid_out !== 1'b0) $display("FAIL reset_valid_out got %b want 0", valid_out);
      else n_pass++;
      n_checks++;
      if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b want 0", frame_done);
      else n_pass++;
      n_checks++;
      if (win_data !== '0) $display("FAIL reset_win_data got %h want 0", win_data);
      else n_pass++;
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_continuous();
    int nw = 0;
    drive_frame(1'b1, 1'b0, NPIX);
    idle(2);
    for (int i = 0; i < NPIX; i++) begin
      n_checks++;
      if (obs_v[i] !== exp_v[i])
        $display("FAIL cont_valid beat %0d got %b want %b", i, obs_v[i], exp_v[i]);
      else n_pass++;
      n_checks++;
      if (obs_fd[i] !== exp_fd[i])
        $display("FAIL cont_frame_done beat %0d got %b want %b", i, obs_fd[i], exp_fd[i]);
      else n_pass++;
      if (exp_v[i]) begin
        n_checks++;
        if (obs_w[i] !== exp_w[i])
          $display("FAIL cont_window beat %0d got %h want %h", i, obs_w[i], exp_w[i]);
        else n_pass++;
      end
      if (obs_v[i] === 1'b1) nw++;
    end
    n_checks++;
    if (nw != NWIN) $display("FAIL cont_count got %0d want %0d", nw, NWIN);
    else n_pass++;
`ifdef CONV_BUF_STRIDE2_EN
    n_checks++;
    if (obs_w[116][7:0] !== 8'd0) $display("FAIL s2_first_e0 got %0d want 0", obs_w[116][7:0]);
    else n_pass++;
    n_checks++;
    if (obs_v[118] !== 1'b1 || obs_w[118][7:0] !== 8'd2)
      $display("FAIL s2_second_e0 got v=%b e0=%0d want v=1 e0=2", obs_v[118], obs_w[118][7:0]);
    else n_pass++;
    n_checks++;
    if (obs_v[172] !== 1'b1 || obs_w[172][7:0] !== 8'd56)
      $display("FAIL s2_13th_e0 got v=%b e0=%0d want v=1 e0=56", obs_v[172], obs_w[172][7:0]);
    else n_pass++;
    n_checks++;
    if (obs_fd[754] !== 1'b1 || obs_w[754][199:192] !== 8'd242)
      $display("FAIL s2_last got fd=%b e24=%0d want fd=1 e24=242",
               obs_fd[754], obs_w[754][199:192]);
    else n_pass++;
`else
    n_checks++;
    if (obs_v[115] !== 1'b0 || obs_v[116] !== 1'b1)
      $display("FAIL first_latency got v115=%b v116=%b want 0,1", obs_v[115], obs_v[116]);
    else n_pass++;
    n_checks++;
    if (obs_w[116][7:0] !== 8'd0 || obs_w[116][39:32] !== 8'd4 ||
        obs_w[116][167:160] !== 8'd112 || obs_w[116][199:192] !== 8'd116)
      $display("FAIL first_elems got e0=%0d e4=%0d e20=%0d e24=%0d want 0,4,112,116",
               obs_w[116][7:0], obs_w[116][39:32], obs_w[116][167:160], obs_w[116][199:192]);
    else n_pass++;
    n_checks++;
    if (obs_fd[783] !== 1'b1 || obs_w[783][199:192] !== 8'd15)
      $display("FAIL last_window got fd=%b e24=%0d want fd=1 e24=15",
               obs_fd[783], obs_w[783][199:192]);
    else n_pass++;
`endif
  endtask

  task automatic test_bubbles();
    int nw = 0;
    drive_frame(1'b1, 1'b1, NPIX);
    idle(2);
    for (int i = 0; i < NPIX; i++) begin
      n_checks++;
      if (obs_v[i] !== exp_v[i])
        $display("FAIL bub_valid beat %0d got %b want %b", i, obs_v[i], exp_v[i]);
      else n_pass++;
      n_checks++;
      if (obs_fd[i] !== exp_fd[i])
        $display("FAIL bub_frame_done beat %0d got %b want %b", i, obs_fd[i], exp_fd[i]);
      else n_pass++;
      n_checks++;
      if (obs_bv[i] !== 1'b0 || obs_bfd[i] !== 1'b0)
        $display("FAIL bub_idle beat %0d got v=%b fd=%b want 0,0", i, obs_bv[i], obs_bfd[i]);
      else n_pass++;
      if (exp_v[i]) begin
        n_checks++;
        if (obs_w[i] !== exp_w[i])
          $display("FAIL bub_window beat %0d got %h want %h", i, obs_w[i], exp_w[i]);
        else n_pass++;
      end
      if (obs_v[i] === 1'b1) nw++;
    end
    n_checks++;
    if (nw != NWIN) $display("FAIL bub_count got %0d want %0d", nw, NWIN);
    else n_pass++;
  endtask

  // Three gap-free frames: sof on the first, natural wrap into the second, sof on the wrap
  // into the third.
  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      int nw = 0;
      drive_frame(f != 1, 1'b0, NPIX);
      for (int i = 0; i < NPIX; i++) begin
        n_checks++;
        if (obs_v[i] !== exp_v[i])
          $display("FAIL b2b_valid frame %0d beat %0d got %b want %b", f, i, obs_v[i], exp_v[i]);
        else n_pass++;
        n_checks++;
        if (obs_fd[i] !== exp_fd[i])
          $display("FAIL b2b_frame_done frame %0d beat %0d got %b want %b",
                   f, i, obs_fd[i], exp_fd[i]);
        else n_pass++;
        if (exp_v[i]) begin
          n_checks++;
          if (obs_w[i] !== exp_w[i])
            $display("FAIL b2b_window frame %0d beat %0d got %h want %h",
                     f, i, obs_w[i], exp_w[i]);
          else n_pass++;
        end
        if (obs_v[i] === 1'b1) nw++;
      end
      n_checks++;
      if (nw != NWIN) $display("FAIL b2b_count frame %0d got %0d want %0d", f, nw, NWIN);
      else n_pass++;
      n_checks++;
      if (obs_v[116] !== 1'b1 || obs_w[116][7:0] !== 8'd0)
        $display("FAIL b2b_first frame %0d got v=%b e0=%0d want v=1 e0=0",
                 f, obs_v[116], obs_w[116][7:0]);
      else n_pass++;
    end
    idle(2);
  endtask

  task automatic test_sof_resync();
    int nw = 0;
    drive_frame(1'b1, 1'b0, 300);
    for (int i = 0; i < 300; i++) begin
      n_checks++;
      if (obs_v[i] !== exp_v[i])
        $display("FAIL sof_partial_valid beat %0d got %b want %b", i, obs_v[i], exp_v[i]);
      else n_pass++;
    end
    drive_frame(1'b1, 1'b0, NPIX);
    idle(2);
    for (int i = 0; i < NPIX; i++) begin
      n_checks++;
      if (obs_v[i] !== exp_v[i])
        $display("FAIL sof_valid beat %0d got %b want %b", i, obs_v[i], exp_v[i]);
      else n_pass++;
      if (exp_v[i]) begin
        n_checks++;
        if (obs_w[i] !== exp_w[i])
          $display("FAIL sof_window beat %0d got %h want %h", i, obs_w[i], exp_w[i]);
        else n_pass++;
      end
      if (obs_v[i] === 1'b1) nw++;
    end
    n_checks++;
    if (nw != NWIN) $display("FAIL sof_count got %0d want %0d", nw, NWIN);
    else n_pass++;
    n_checks++;
    if (obs_v[115] !== 1'b0 || obs_v[116] !== 1'b1 || obs_w[116][7:0] !== 8'd0)
      $display("FAIL sof_first got v115=%b v116=%b e0=%0d want 0,1,0",
               obs_v[115], obs_v[116], obs_w[116][7:0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int nw = 0;
    drive_frame(1'b1, 1'b0, 200);
    rst_n    = 1'b0;
    valid_in = 1'b1;
    data_in  = 8'h33;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (valid_out !== 1'b0 || frame_done !== 1'b0 || win_data !== '0)
        $display("FAIL midrst_outputs cycle %0d got v=%b fd=%b win=%h want all 0",
                 i, valid_out, frame_done, win_data);
      else n_pass++;
    end
    rst_n = 1'b1;
    drive_frame(1'b0, 1'b0, NPIX);  // no sof: first beat after reset is (0,0)
    idle(2);
    for (int i = 0; i < NPIX; i++) begin
      n_checks++;
      if (obs_v[i] !== exp_v[i])
        $display("FAIL midrst_valid beat %0d got %b want %b", i, obs_v[i], exp_v[i]);
      else n_pass++;
      n_checks++;
      if (obs_fd[i] !== exp_fd[i])
        $display("FAIL midrst_frame_done beat %0d got %b want %b", i, obs_fd[i], exp_fd[i]);
      else n_pass++;
      if (exp_v[i]) begin
        n_checks++;
        if (obs_w[i] !== exp_w[i])
          $display("FAIL midrst_window beat %0d got %h want %h", i, obs_w[i], exp_w[i]);
        else n_pass++;
      end
      if (obs_v[i] === 1'b1) nw++;
    end
    n_checks++;
    if (nw != NWIN) $display("FAIL midrst_count got %0d want %0d", nw, NWIN);
    else n_pass++;
  endtask

  initial begin
    build_expected();
    test_reset();
    test_continuous();
    test_bubbles();
    test_back_to_back();
    test_sof_resync();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/conv_window_buf.md
# conv_window_buf

Parametrised streaming K×K sliding-window generator for the convolution layers of the MNIST CNN datapath. It accepts one raster-order pixel per `valid_in` beat and emits a registered K×K window, flattened onto one bus, for every valid convolution position (valid padding, stride 1). It tolerates input bubbles and supports explicit frame resynchronisation. It sits between the pixel source or previous pooling stage and the multiply-accumulate array.

## Interface
- `IMG_W`, 28, image width in pixels (≥ K)
- `IMG_H`, 28, image height in pixels (≥ K)
- `K`, 5, kernel side (≥ 2)
- `DATA_BITS`, 8, pixel width
- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `valid_in`  in  1  pixel beat qualifier
- `sof`  in  1  start of frame, sampled only with `valid_in`; marks the pixel as (0,0)
- `data_in`  in  DATA_BITS  pixel
- `win_data`  out  K*K*DATA_BITS  window; element r*K+c at bits [(r*K+c)*DATA_BITS +: DATA_BITS], r=0 top (oldest) row, c=0 leftmost column
- `valid_out`  out  1  `win_data` holds a new window this cycle (one-cycle pulse per window)
- `frame_done`  out  1  pulses together with the last window of a frame

## Operation
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) advance only on accepted beats (`valid_in`=1). `col` wraps to 0 and increments `row`. After (IMG_H-1, IMG_W-1), both wrap to 0.
- `valid_in && sof` forces the current pixel to (0,0). Counters continue from (0,1). Data from any earlier partial frame is never emitted.
- Storage: K-1 row delay lines of IMG_W entries each, plus a K×K shift-register window. Each accepted beat shifts the window left by one column. The new right column is the K-1 delayed pixels plus `data_in`.
- A window is emitted for an accepted beat when `row ≥ K-1` and `col ≥ K-1`. Its contents are rows row-K+1..row and columns col-K+1..col.
- Windows per frame: (IMG_H-K+1)×(IMG_W-K+1). The default is 576.
- `frame_done` is asserted with the window for pixel (IMG_H-1, IMG_W-1).
- No backpressure: the downstream stage consumes every `valid_out` pulse.
- Counter widths are $clog2 of their range. Data is never modified; widths are preserved.

## Timing
- Latency: `valid_out` rises exactly 1 cycle after the accepted beat that completes a window.
- Without bubbles, `valid_out` is high IMG_W-K+1 consecutive cycles per row, then low K-1 cycles.
- Bubbles (`valid_in`=0) freeze all state. `valid_out` and `frame_done` are 0 during the cycle following a bubble.
- Reset values:
  - `valid_out`=0, `frame_done`=0, `win_data`=0
  - counters=0
  - delay-line contents don't-care, never emitted before refill
- Reset asserted mid-frame aborts the frame. The first beat after reset is treated as (0,0) whether or not `sof` is asserted.
- If `sof` arrives on the same beat as a frame wrap, the result is consistent: the pixel is (0,0) either way.

## Configuration
- `CONV_BUF_STRIDE2_EN`
  - Defined: windows are emitted only where (row-K+1) and (col-K+1) are both even. The default produces 12×12=144 windows per frame.
  - `frame_done` accompanies the last emitted window: the one at row-K+1 = col-K+1 = largest even position, i.e. pixel (IMG_H-2, IMG_W-2) for the defaults.
  - Undefined: stride 1 as above.
  - Latency and reset behaviour are identical in both builds.

## Structure
- Shared package `conv_pkg`: default IMG_W/IMG_H/K/DATA_BITS constants and a `win_idx(r,c)` function returning r*K+c, shared with the MAC array.
- Sub-module `conv_line_delay`: single-row delay line, IMG_W×DATA_BITS, with shift enable. K-1 instances, chained.

## Test plan
- Ramp frame, pixel = (r*28+c) mod 256, continuous `valid_in`:
  - first `valid_out` 1 cycle after beat 116, with element0=0, element4=4, element20=112, element24=116
  - 576 windows total
  - last window element24=15 (783 mod 256) with `frame_done`=1
- Same ramp with `valid_in` toggled every cycle (50% duty): window sequence and contents identical to continuous, every `valid_out` one cycle after its beat.
- Two back-to-back frames with no gap: second frame's first window appears after its beat 116 with element0=0 (the second frame repeats the ramp), with no stale windows in between.
- `sof` reasserted at beat 300 of frame 1, then a full ramp: no window from the aborted data, and the next window after 117 beats has element0=0.
- `rst_n` low 2 cycles at beat 200: all outputs 0 during reset. After reset, a full ramp yields exactly 576 windows.
- `CONV_BUF_STRIDE2_EN` build, ramp frame:
  - 144 windows
  - first element0=0, second element0=2
  - 13th window (second output row) element0=56
  - `frame_done` on the window whose element24 = 26*28+26 = 754 → 242 (mod 256)
